hdmux4_arbiter: RTL



---
 rtl/hdmux4_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hdmux4_arbiter.sv
// hdmux4_arbiter
//   Round-robin arbiter and select sequencer for one shared 4:1 inverting
//   mux lane (Z = ~A[sel]). It drives the mux selects, inserts a settle gap
//   whenever the select changes, grants one requester at a time with a
//   bounded burst, and returns the re-inverted, registered mux output.
//
//   Optional build macro: HDMUX4_ARB_LOCK_EN adds the LOCK input. While LOCK
//   is high in OWN, the burst limit is suspended for the current owner.
//
// Ports:
//   CK      clock, rising edge
//   RN      synchronous active-low reset
//   LOCK    (HDMUX4_ARB_LOCK_EN only) hold the lane past MAX_BURST
//   REQ     level request per mux input A0..A3
//   GNT     one-hot registered grant
//   SL0/SL1 mux select bits
//   ZN      mux output (inverted data)
//   DOUT    registered ~ZN
//   DVALID  DOUT carries owner data
//   OWNER   current or most recent owner index
//   BUSY    arbiter not idle
module hdmux4_arbiter #(
  parameter int MAX_BURST  = 8,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic       CK,
  input  logic       RN,
`ifdef HDMUX4_ARB_LOCK_EN
  input  logic       LOCK,
`endif
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       SL0,
  output logic       SL1,
  input  logic       ZN,
  output logic       DOUT,
  output logic       DVALID,
  output logic [1:0] OWNER,
  output logic       BUSY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OWN    = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [1:0]       owner_reg, owner_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [3:0]       timer_reg, timer_next;
  logic             dout_reg;
  logic             dvalid_reg;

  logic             lock_act;
  logic [1:0]       arb_ptr;
  logic [3:0]       rot_req;
  logic [1:0]       win_off;
  logic [1:0]       win;
  logic [3:0]       win_hot;
  logic [3:0]       own_hot;
  logic             own_req;
  logic             others_req;
  logic             burst_done;
  logic             start_arb;

`ifdef HDMUX4_ARB_LOCK_EN
  assign lock_act = LOCK;
`else
  assign lock_act = 1'b0;
`endif

  // Leaving OWN moves the pointer to the outgoing owner in the same cycle,
  // so the re-arbitration scans from owner_reg rather than ptr_reg.
  assign arb_ptr = (state_reg == ST_OWN) ? owner_reg : ptr_reg;

  // rot_req[k] is the request k+1 positions after the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFFS = 2'(gi + 1);
      logic [1:0] idx;
      assign idx         = arb_ptr + OFFS;
      assign rot_req[gi] = REQ[idx];
      assign win_hot[gi] = (win == 2'(gi));
      assign own_hot[gi] = (owner_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    win_off = 2'd3;
    if (rot_req[0])      win_off = 2'd0;
    else if (rot_req[1]) win_off = 2'd1;
    else if (rot_req[2]) win_off = 2'd2;
  end

  assign win        = arb_ptr + win_off + 2'd1;
  assign own_req    = |(REQ & own_hot);
  assign others_req = |(REQ & ~own_hot);
  assign burst_done = (count_reg == CNT_W'(MAX_BURST));

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    owner_next = owner_reg;
    gnt_next   = gnt_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    start_arb  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        start_arb = |REQ;
      end
      ST_SETTLE: begin
        gnt_next = 4'b0000;
        if (!own_req) begin
          // Requester gave up while the mux settled; pointer and select hold.
          state_next = ST_IDLE;
        end else if (timer_reg <= 4'd1) begin
          state_next = ST_OWN;
          gnt_next   = own_hot;
          count_next = CNT_W'(1);
        end else begin
          timer_next = timer_reg - 4'd1;
        end
      end
      ST_OWN: begin
        if (!own_req || (burst_done && others_req && !lock_act)) begin
          ptr_next   = owner_reg;
          gnt_next   = 4'b0000;
          state_next = ST_IDLE;
          start_arb  = |REQ;
        end else if (burst_done) begin
          // Sole requester restarts its burst; a locked owner saturates.
          count_next = lock_act ? count_reg : CNT_W'(1);
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = 4'b0000;
      end
    endcase

    // Shared arbitration step for IDLE and for the exit from OWN.
    if (start_arb) begin
      sel_next   = win;
      owner_next = win;
      if ((win == sel_reg) || (SETTLE_CYC == 0)) begin
        state_next = ST_OWN;
        gnt_next   = win_hot;
        count_next = CNT_W'(1);
      end else begin
        state_next = ST_SETTLE;
        gnt_next   = 4'b0000;
        timer_next = 4'(SETTLE_CYC);
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= 2'd3;
      sel_reg    <= 2'd0;
      owner_reg  <= 2'd0;
      gnt_reg    <= 4'b0000;
      count_reg  <= '0;
      timer_reg  <= 4'd0;
      dout_reg   <= 1'b0;
      dvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      sel_reg    <= sel_next;
      owner_reg  <= owner_next;
      gnt_reg    <= gnt_next;
      count_reg  <= count_next;
      timer_reg  <= timer_next;
      dout_reg   <= ~ZN;
      dvalid_reg <= (state_reg == ST_OWN) && own_req;
    end
  end

  assign GNT    = gnt_reg;
  assign SL0    = sel_reg[0];
  assign SL1    = sel_reg[1];
  assign DOUT   = dout_reg;
  assign DVALID = dvalid_reg;
  assign OWNER  = owner_reg;
  assign BUSY   = (state_reg != ST_IDLE);

endmodule
